// File: rtl/memory_game_pkg.sv
// Shared types and constants for the memory game input path.
// Guess width, debounce FSM encoding and default debounce length.
package memory_game_pkg;

    localparam int GUESS_W = 4;

    localparam int DEBOUNCE_CYCLES_DEFAULT = 1000000;

    typedef enum logic [1:0] {
        IDLE_LOW  = 2'd0,
        WAIT_HIGH = 2'd1,
        HELD_HIGH = 2'd2,
        WAIT_LOW  = 2'd3
    } deb_state_t;

    // Width of a counter that can hold the value n.
    function automatic int cnt_width(input int n);
        return (n < 1) ? 1 : $clog2(n + 1);
    endfunction

endpackage

// File: rtl/bit_synchronizer.sv
// Multi-stage flip-flop synchronizer for asynchronous inputs.
// Every bit of the bus is synchronized independently.
module bit_synchronizer #(
    parameter int STAGES = 2,
    parameter int WIDTH  = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_sync [STAGES];

    // Shift the raw input through the synchronizer chain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < STAGES; i++) begin
                r_sync[i] <= '0;
            end
        end else begin
            r_sync[0] <= i_d;
            for (int i = 1; i < STAGES; i++) begin
                r_sync[i] <= r_sync[i-1];
            end
        end
    end

    assign o_q = r_sync[STAGES-1];

endmodule

// File: rtl/guess_input_conditioner.sv
// Synchronizes, debounces and latches a guess for the game core.
// Press events load the switches into a valid/ready output register.
module guess_input_conditioner
    import memory_game_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
    parameter int SYNC_STAGES     = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               btn0,
    input  logic [GUESS_W-1:0] switches,
    output logic [GUESS_W-1:0] guess,
    output logic               guess_valid,
    input  logic               guess_ready,
    output logic               btn_level,
    output logic               overrun
);

    localparam int CNT_W = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    logic               w_btn_s;
    logic [GUESS_W-1:0] w_sw_s;

    deb_state_t         r_state;
    deb_state_t         w_next;
    logic [CNT_W-1:0]   r_cnt;
    logic               w_press;
    logic               w_level;

    logic [GUESS_W-1:0] r_guess;
    logic               r_valid;
    logic               r_overrun;

    bit_synchronizer #(
        .STAGES (SYNC_STAGES),
        .WIDTH  (1)
    ) u_sync_btn (
        .clk   (clk),
        .rst_n (rst_n),
        .i_d   (btn0),
        .o_q   (w_btn_s)
    );

    bit_synchronizer #(
        .STAGES (SYNC_STAGES),
        .WIDTH  (GUESS_W)
    ) u_sync_sw (
        .clk   (clk),
        .rst_n (rst_n),
        .i_d   (switches),
        .o_q   (w_sw_s)
    );

    // Debounce FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE_LOW;
        end else begin
            r_state <= w_next;
        end
    end

    // Debounce FSM next-state decode.
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE_LOW: begin
                if (w_btn_s) begin
                    w_next = WAIT_HIGH;
                end
            end
            WAIT_HIGH: begin
                if (!w_btn_s) begin
                    w_next = IDLE_LOW;
                end else if (r_cnt == CNT_LAST) begin
                    w_next = HELD_HIGH;
                end
            end
            HELD_HIGH: begin
                if (!w_btn_s) begin
                    w_next = WAIT_LOW;
                end
            end
            WAIT_LOW: begin
                if (w_btn_s) begin
                    w_next = HELD_HIGH;
                end else if (r_cnt == CNT_LAST) begin
                    w_next = IDLE_LOW;
                end
            end
            default: begin
                w_next = IDLE_LOW;
            end
        endcase
    end

    // Debounce FSM outputs: press event on accepted rise, stable level.
    always_comb begin
        w_press = 1'b0;
        w_level = 1'b0;
        unique case (r_state)
            IDLE_LOW: begin
                w_level = 1'b0;
            end
            WAIT_HIGH: begin
                w_press = (w_next == HELD_HIGH);
            end
            HELD_HIGH: begin
                w_level = 1'b1;
            end
            WAIT_LOW: begin
                w_level = 1'b1;
            end
            default: begin
                w_level = 1'b0;
            end
        endcase
    end

    // Stability counter: clears on any state change, saturates otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (w_next != r_state) begin
            r_cnt <= '0;
        end else if ((r_state == WAIT_HIGH) || (r_state == WAIT_LOW)) begin
            if (r_cnt != CNT_MAX) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

    // Guess register with valid/ready handshake; a press on a
    // completing handshake reloads, otherwise a busy press is dropped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_guess <= '0;
            r_valid <= 1'b0;
        end else if (w_press && (!r_valid || guess_ready)) begin
            r_guess <= w_sw_s;
            r_valid <= 1'b1;
        end else if (r_valid && guess_ready) begin
            r_valid <= 1'b0;
        end
    end

    // One-cycle flag for a press dropped while a guess is pending.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_overrun <= 1'b0;
        end else begin
            r_overrun <= w_press && r_valid && !guess_ready;
        end
    end

    assign guess       = r_guess;
    assign guess_valid = r_valid;
    assign btn_level   = w_level;
    assign overrun     = r_overrun;

endmodule
